// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Stream format: 16-bit little-endian word count N, then N little-endian 32-bit words.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int WORD_W         = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  // States in which a new load may be requested.
  function automatic logic can_start(input loader_state_t s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

  // States that count as a load in progress.
  function automatic logic is_busy(input loader_state_t s);
    return (s == HDR0) || (s == HDR1) || (s == DATA) || (s == WRITE);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in lane k.
// word_valid flags the load that completes the current word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [1:0] cnt_reg;
  logic [1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = 2'd0;
    end else if (load) begin
      cnt_next = cnt_reg + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 2'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign word_valid = load && !clear && (cnt_reg == 2'(BYTES_PER_WORD - 1));

  // Each lane captures only the byte whose position matches the counter.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [7:0] lane_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg <= 8'd0;
        end else if (load && !clear && (cnt_reg == 2'(gi))) begin
          lane_reg <= data;
        end
      end

      assign word[gi*8 +: 8] = lane_reg;
    end
  endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count + words from a byte stream, writes instruction memory,
// and keeps the core in reset until the whole program has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded,
  output logic              core_rst_n
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  loader_state_t state_reg;
  loader_state_t state_next;

  logic [15:0]       n_reg;
  logic [15:0]       n_next;
  logic [15:0]       words_loaded_reg;
  logic [15:0]       words_loaded_next;

  logic              xfer;
  logic              start_ok;
  logic              pack_load;
  logic              pack_clear;
  logic [WORD_W-1:0] pack_word;
  logic              pack_word_valid;

  assign s_ready  = (state_reg == HDR0) || (state_reg == HDR1) || (state_reg == DATA);
  assign xfer     = s_valid && s_ready;
  assign start_ok = start && can_start(state_reg);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (pack_load),
    .clear      (pack_clear),
    .data       (s_data),
    .word       (pack_word),
    .word_valid (pack_word_valid)
  );

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    pack_load  = 1'b0;
    pack_clear = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (start_ok) begin
          state_next = HDR0;
          pack_clear = 1'b1;
        end
      end

      HDR0: begin
        if (xfer) begin
          n_next     = {n_reg[15:8], s_data};
          state_next = HDR1;
        end
      end

      HDR1: begin
        if (xfer) begin
          n_next = {s_data, n_reg[7:0]};
          if (n_next == 16'd0) begin
            state_next = DONE;
          end else if ({1'b0, n_next} > DEPTH_LIM) begin
            state_next = ERR;
          end else begin
            state_next = DATA;
          end
        end
      end

      DATA: begin
        pack_load = xfer;
        if (pack_word_valid) begin
          state_next = WRITE;
        end
      end

      WRITE: begin
        if ((words_loaded_reg + 16'd1) == n_reg) begin
          state_next = DONE;
        end else begin
          state_next = DATA;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Word counter doubles as the write index, so it advances at the end of WRITE.
  always_comb begin
    words_loaded_next = words_loaded_reg;
    if (start_ok) begin
      words_loaded_next = 16'd0;
    end else if (state_reg == WRITE) begin
      words_loaded_next = words_loaded_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      n_reg            <= 16'd0;
      words_loaded_reg <= 16'd0;
    end else begin
      state_reg        <= state_next;
      n_reg            <= n_next;
      words_loaded_reg <= words_loaded_next;
    end
  end

  assign imem_we      = (state_reg == WRITE);
  assign imem_addr    = ADDR_W'({words_loaded_reg, 2'b00});
  assign imem_wdata   = pack_word;
  assign busy         = is_busy(state_reg);
  assign done         = (state_reg == DONE);
  assign error        = (state_reg == ERR);
  assign words_loaded = words_loaded_reg;
  // The core only runs once a complete program sits in memory.
  assign core_rst_n   = (state_reg == DONE);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time loader for the single-cycle processor's instruction memory. It receives a byte stream carrying a word count and little-endian 32-bit instructions, then writes each assembled instruction into `instruction_memory` through its write port. It holds the core in reset until the program is fully written, and releases it only then. It sits between the external download interface and `instruction_memory`, and drives the core's reset.

## Interface
Parameters:
- `DEPTH_WORDS`, 256, instruction memory capacity in 32-bit words.
- `ADDR_W`, 32, width of the byte address driven to instruction memory.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction memory write enable.
- `imem_addr`  out  ADDR_W  byte address (word index × 4).
- `imem_wdata`  out  32  instruction to write.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed successfully.
- `error`  out  1  last load rejected (count too large).
- `words_loaded`  out  16  words written in the current or last load.
- `core_rst_n`  out  1  active-low reset to the processor core.

## Operation
- FSM states: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- A byte transfer occurs when `s_valid && s_ready`. `s_ready` = 1 only in HDR0, HDR1 and DATA.
- IDLE/DONE/ERR + `start` → HDR0. This clears `done`, `error` and `words_loaded`, and drives `core_rst_n` = 0. `start` in any other state is ignored.
- HDR0: the accepted byte is N[7:0] → HDR1. HDR1: the accepted byte is N[15:8].
- On leaving HDR1:
  - N = 0 → DONE.
  - N > `DEPTH_WORDS` → ERR.
  - Otherwise → DATA.
- DATA: accepted bytes are packed little-endian (first byte is [7:0]). The 4th byte → WRITE.
- WRITE lasts exactly one cycle:
  - `imem_we` = 1, `imem_addr` = word_idx×4, `imem_wdata` = the packed word.
  - `words_loaded` increments.
  - Next state: DONE if `words_loaded` reaches N, else DATA.
- DONE: `done` = 1 and `core_rst_n` = 1.
- ERR: `error` = 1, `core_rst_n` stays 0 and no writes occur. The state is sticky until `start`.
- `busy` = 1 in HDR0, HDR1, DATA and WRITE.
- Memory contents are never cleared by the loader. A reset mid-load leaves partially written words in memory.

## Timing
- All outputs are registered or decoded from state only; there is no combinational path from `s_valid`/`s_data` to any output.
- Reset value of every output is 0: `s_ready`, `imem_we`, `imem_addr`, `imem_wdata`, `busy`, `done`, `error`, `words_loaded`, `core_rst_n`.
- Reset is asynchronous: asserting `rst_n` forces all outputs to their reset values immediately and the state to IDLE, mid-operation included.
- Latency: the 4th byte accepted at edge k gives `imem_we` high for the cycle between edges k and k+1. No byte is accepted in that cycle.
- Best-case throughput is 5 cycles per word.
- `start` is sampled at the edge; `busy` is high from the next cycle.
- `core_rst_n` rises the first cycle in DONE and falls the cycle after an accepted `start`.
- `s_data` must be held while `s_valid` = 1 and `s_ready` = 0. The loader never drops or duplicates a byte across WRITE cycles.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `BYTES_PER_WORD` = 4;
  - `HDR_BYTES` = 2;
  - `WORD_W` = 32.
- Sub-module `byte_packer` holds the 4-byte little-endian shift/assemble register and its 2-bit byte counter. It exposes `load`, `clear` and `word_valid`.
- The top level holds the FSM, the word counter and the address generation.

## Test plan
- Program load: N = 3, bytes 03 00 13 00 00 00 93 00 50 00 13 01 A0 00. Required response: three `imem_we` pulses at addr 0/4/8 with data 00000013/00500093/00A00113; then `done` = 1, `core_rst_n` = 1, `words_loaded` = 3.
- Backpressure: same stream with `s_valid` toggling every other cycle and bytes presented during WRITE. Required response: identical writes, with `s_ready` = 0 exactly during WRITE and no bytes lost.
- Empty load: bytes 00 00. Required response: DONE two transfers after `start`, no `imem_we`, `core_rst_n` = 1.
- Oversize: bytes 01 01 (N = 257, `DEPTH_WORDS` = 256). Required response: `error` = 1, `s_ready` = 0, no writes, `core_rst_n` = 0; then `start` plus a valid stream loads normally.
- Reset mid-load: drop `rst_n` after 6 bytes. Required response: all outputs 0 in the same cycle and state IDLE; the following load of N = 1 writes addr 0 correctly.
- Restart: `start` while busy is ignored. `start` in DONE drops `core_rst_n` the next cycle and reloads from addr 0.
